// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
//
// Shares the single AHB slave port of the AHB-to-APB bridge between
// NUM_MASTERS AHB masters. Round-robin arbitration that never breaks an
// in-progress burst or a locked sequence, with a beat-count hold limit
// (MAX_HOLD) after which an unlocked owner yields to another requester.
//
// Optional build macro: ARB_FIXED_PRIORITY_EN
//   defined   - lowest-index requester wins; the MAX_HOLD yield only happens
//               when a lower-index master is requesting.
//   undefined - round-robin starting at (owner+1) mod NUM_MASTERS.
//
// Ports:
//   Hclk       in   bus clock, rising edge
//   Hreset     in   synchronous active-high reset
//   Hbusreq    in   [NUM_MASTERS] per-master bus request
//   Hlock      in   [NUM_MASTERS] per-master locked-sequence request
//   Htrans     in   [2] transfer type of the current address-phase owner
//   Hready     in   Hreadyout from the bridge
//   Hgrant     out  [NUM_MASTERS] one-hot grant (registered)
//   Hmaster    out  [2] address-phase owner index (registered)
//   Hmastlock  out  current address phase is locked (registered)
// ---------------------------------------------------------------------------
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int MAX_HOLD    = 8
) (
    input  logic                   Hclk,
    input  logic                   Hreset,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic [1:0]             Htrans,
    input  logic                   Hready,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [1:0]             Hmaster,
    output logic                   Hmastlock
);

    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [3:0] HOLD_LIMIT   = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE_PARK = 2'b00,
        OWNED     = 2'b01,
        HANDOVER  = 2'b10
    } arb_state_e;

    arb_state_e             state_q, state_d;
    // owner_q is both the granted index and the round-robin pointer.
    logic [1:0]             owner_q, owner_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [1:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [3:0]             beat_cnt_q, beat_cnt_d;

    logic                   mid_burst_s;
    logic                   yield_req_s;
    logic                   rearb_s;
    logic [1:0]             winner_s;

    // One-hot encode a master index.
    function automatic logic [NUM_MASTERS-1:0] to_onehot(input logic [1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v = {NUM_MASTERS{1'b0}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (idx == 2'(i)) begin
                v[2'(i)] = 1'b1;
            end else begin
                v[2'(i)] = v[2'(i)];
            end
        end
        return v;
    endfunction

    // First requester searching upward from owner+1, wrapping; park on 0.
    function automatic logic [1:0] pick_rr(input logic [NUM_MASTERS-1:0] req,
                                           input logic [1:0] owner);
        logic [1:0] win;
        logic       found;
        logic [1:0] idx;
        int         c;
        win   = 2'b00;
        found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            c = int'(owner) + k;
            if (c >= NUM_MASTERS) begin
                c = c - NUM_MASTERS;
            end else begin
                c = c;
            end
            idx = 2'(c);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    // Lowest-index requester; park on 0.
    function automatic logic [1:0] pick_fixed(input logic [NUM_MASTERS-1:0] req);
        logic [1:0] win;
        win = 2'b00;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[2'(i)]) begin
                win = 2'(i);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Any requester with an index below the owner.
    function automatic logic lower_req(input logic [NUM_MASTERS-1:0] req,
                                       input logic [1:0] owner);
        logic any;
        any = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if ((2'(i) < owner) && req[2'(i)]) begin
                any = 1'b1;
            end else begin
                any = any;
            end
        end
        return any;
    endfunction

    // Arbitration decision for this edge.
    always_comb begin
        mid_burst_s = (Htrans == TRANS_SEQ) || (Htrans == TRANS_BUSY);
`ifdef ARB_FIXED_PRIORITY_EN
        yield_req_s = lower_req(Hbusreq, owner_q);
        winner_s    = pick_fixed(Hbusreq);
`else
        yield_req_s = |(Hbusreq & ~hgrant_q);
        winner_s    = pick_rr(Hbusreq, owner_q);
`endif
        // No re-arbitration while a handover is still waiting for Hmaster.
        rearb_s = (state_q != HANDOVER) && Hready && !mid_burst_s &&
                  !Hlock[owner_q] &&
                  (!Hbusreq[owner_q] || ((beat_cnt_q == HOLD_LIMIT) && yield_req_s));
    end

    // Next-state values; Hready low freezes everything.
    always_comb begin
        owner_d     = owner_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        beat_cnt_d  = beat_cnt_q;
        state_d     = state_q;
        if (Hready) begin
            if (rearb_s) begin
                owner_d = winner_s;
            end else begin
                owner_d = owner_q;
            end
            // Address-phase owner follows the grant one ready edge later.
            if (owner_q != hmaster_q) begin
                hmaster_d = owner_q;
            end else begin
                hmaster_d = hmaster_q;
            end
            hmastlock_d = Hlock[hmaster_d];
            if (owner_d != owner_q) begin
                beat_cnt_d = 4'd0;
            end else if (((Htrans == TRANS_NONSEQ) || (Htrans == TRANS_SEQ)) &&
                         (beat_cnt_q < HOLD_LIMIT)) begin
                beat_cnt_d = beat_cnt_q + 4'd1;
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
            if (owner_d != hmaster_d) begin
                state_d = HANDOVER;
            end else if (Hbusreq[owner_d]) begin
                state_d = OWNED;
            end else begin
                state_d = IDLE_PARK;
            end
        end else begin
            owner_d = owner_q;
        end
        hgrant_d = to_onehot(owner_d);
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q     <= IDLE_PARK;
            owner_q     <= 2'd0;
            hgrant_q    <= to_onehot(2'd0);
            hmaster_q   <= 2'd0;
            hmastlock_q <= 1'b0;
            beat_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign Hgrant    = hgrant_q;
    assign Hmaster   = hmaster_q;
    assign Hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios followed by
// random traffic, all checked by a scoreboard fed from a reference model.
module tb_ahb_bus_arbiter;

    localparam int N    = 3;
    localparam int MAXH = 8;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

`ifdef ARB_FIXED_PRIORITY_EN
    localparam logic [2:0] AFTER_BURST = 3'b001;
    localparam logic [2:0] AFTER_HOLD  = 3'b001;
    localparam logic [2:0] AFTER_FREEZE = 3'b001;
`else
    localparam logic [2:0] AFTER_BURST = 3'b100;
    localparam logic [2:0] AFTER_HOLD  = 3'b100;
    localparam logic [2:0] AFTER_FREEZE = 3'b100;
`endif

    logic       Hclk;
    logic       Hreset;
    logic [2:0] Hbusreq;
    logic [2:0] Hlock;
    logic [1:0] Htrans;
    logic       Hready;
    logic [2:0] Hgrant;
    logic [1:0] Hmaster;
    logic       Hmastlock;

    ahb_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MAXH)) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hbusreq   (Hbusreq),
        .Hlock     (Hlock),
        .Htrans    (Htrans),
        .Hready    (Hready),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Hmastlock (Hmastlock)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0] grant;
        logic [1:0] master;
        logic       lock;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: who holds the grant, who owns the address
    // phase, the lock flag and the beats the owner has used.
    int m_owner  = 0;
    int m_master = 0;
    int m_count  = 0;
    bit m_lock   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pick(input logic [2:0] req, input int owner);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int c = 0; c < N; c++) if (req[c]) return c;
`else
        for (int k = 1; k <= N; k++) if (req[(owner + k) % N]) return (owner + k) % N;
`endif
        return 0;
    endfunction

    task automatic model_step(input logic [2:0] req, input logic [2:0] lk,
                              input logic [1:0] tr, input logic rdy, input logic rst);
        int  new_owner;
        int  new_master;
        bit  yield;
        exp_t e;
        if (rst) begin
            m_owner = 0; m_master = 0; m_lock = 1'b0; m_count = 0;
        end else if (rdy) begin
            new_owner = m_owner;
            if (m_owner == m_master && tr != 2'b01 && tr != 2'b11 && !lk[m_owner]) begin
                yield = 1'b0;
                for (int c = 0; c < N; c++) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    if (c < m_owner && req[c]) yield = 1'b1;
`else
                    if (c != m_owner && req[c]) yield = 1'b1;
`endif
                end
                if (!req[m_owner] || (m_count == MAXH && yield))
                    new_owner = ref_pick(req, m_owner);
            end
            new_master = (m_owner != m_master) ? m_owner : m_master;
            m_lock = lk[new_master];
            if (new_owner != m_owner) m_count = 0;
            else if (tr[1] && m_count < MAXH) m_count++;
            m_owner  = new_owner;
            m_master = new_master;
        end
        e.grant  = 3'(1 << m_owner);
        e.master = 2'(m_master);
        e.lock   = m_lock;
        exp_q.push_back(e);
    endtask

    // Drive one cycle at the falling edge, predict, and return just after
    // the rising edge that consumes it.
    task automatic cyc(input logic [2:0] req, input logic [2:0] lk,
                       input logic [1:0] tr, input logic rdy, input logic rst);
        @(negedge Hclk);
        Hbusreq = req; Hlock = lk; Htrans = tr; Hready = rdy; Hreset = rst;
        model_step(req, lk, tr, rdy, rst);
        @(posedge Hclk);
        #1;
    endtask

    // Scoreboard monitor: one expectation per clock edge after stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge Hclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_grant", 32'(Hgrant), 32'(e.grant));
                check("sb_master", 32'(Hmaster), 32'(e.master));
                check("sb_mastlock", 32'(Hmastlock), 32'(e.lock));
                check("sb_onehot", 32'($onehot(Hgrant)), 32'd1);
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Hreset = 1'b1; Hbusreq = 3'b000; Hlock = 3'b000; Htrans = T_IDLE; Hready = 1'b1;

        // Reset and idle parking.
        cyc(3'b000, 3'b000, T_IDLE, 1'b1, 1'b1);
        cyc(3'b000, 3'b000, T_IDLE, 1'b1, 1'b1);
        check("rst_grant", 32'(Hgrant), 32'h1);
        check("rst_master", 32'(Hmaster), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(3'b000, 3'b000, T_IDLE, 1'b1, 1'b0);
            check("park_grant", 32'(Hgrant), 32'h1);
            check("park_lock", 32'(Hmastlock), 32'h0);
        end

        // Grant moves to master 1, Hmaster follows, then release to 2.
        cyc(3'b110, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("hand_grant", 32'(Hgrant), 32'h2);
        check("hand_master_old", 32'(Hmaster), 32'h0);
        cyc(3'b110, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("hand_master_new", 32'(Hmaster), 32'h1);
        cyc(3'b100, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("release_grant", 32'(Hgrant), 32'h4);

        // Master 1 owns again, runs a 4-beat burst.
        repeat (3) cyc(3'b010, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("burst_owner", 32'(Hmaster), 32'h1);
        cyc(3'b111, 3'b000, T_NONSEQ, 1'b1, 1'b0);
        check("burst_b1", 32'(Hgrant), 32'h2);
        cyc(3'b111, 3'b000, T_SEQ, 1'b1, 1'b0);
        check("burst_b2", 32'(Hgrant), 32'h2);
        cyc(3'b111, 3'b000, T_SEQ, 1'b1, 1'b0);
        check("burst_b3", 32'(Hgrant), 32'h2);
        cyc(3'b101, 3'b000, T_SEQ, 1'b1, 1'b0);
        check("burst_b4", 32'(Hgrant), 32'h2);
        cyc(3'b101, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("burst_after", 32'(Hgrant), 32'(AFTER_BURST));

        // Master 0 streams beats while master 2 waits for MAX_HOLD.
        repeat (4) cyc(3'b001, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("hold_owner", 32'(Hmaster), 32'h0);
        for (int i = 0; i < MAXH; i++) begin
            cyc(3'b101, 3'b000, T_NONSEQ, 1'b1, 1'b0);
            check("hold_keep", 32'(Hgrant), 32'h1);
        end
        cyc(3'b101, 3'b000, T_NONSEQ, 1'b1, 1'b0);
        check("hold_yield", 32'(Hgrant), 32'(AFTER_HOLD));

        // Locked sequence on master 0.
        repeat (4) cyc(3'b001, 3'b000, T_IDLE, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(3'b111, 3'b001, T_NONSEQ, 1'b1, 1'b0);
            check("lock_grant", 32'(Hgrant), 32'h1);
            check("lock_flag", 32'(Hmastlock), 32'h1);
        end
        cyc(3'b110, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("unlock_grant", 32'(Hgrant), 32'h2);
        check("unlock_flag", 32'(Hmastlock), 32'h0);

        // Wait states freeze the handover and an arbitration point.
        repeat (3) begin
            cyc(3'b110, 3'b000, T_IDLE, 1'b0, 1'b0);
            check("freeze_grant", 32'(Hgrant), 32'h2);
            check("freeze_master", 32'(Hmaster), 32'h0);
        end
        cyc(3'b110, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("thaw_master", 32'(Hmaster), 32'h1);
        repeat (3) begin
            cyc(3'b101, 3'b000, T_IDLE, 1'b0, 1'b0);
            check("freeze_arb", 32'(Hgrant), 32'h2);
        end
        cyc(3'b101, 3'b000, T_IDLE, 1'b1, 1'b0);
        check("thaw_arb", 32'(Hgrant), 32'(AFTER_FREEZE));

        // Reset in the middle of a burst, with Hready low.
        cyc(3'b100, 3'b000, T_NONSEQ, 1'b1, 1'b0);
        cyc(3'b100, 3'b000, T_SEQ, 1'b0, 1'b1);
        check("midrst_grant", 32'(Hgrant), 32'h1);
        check("midrst_master", 32'(Hmaster), 32'h0);
        check("midrst_lock", 32'(Hmastlock), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cyc(3'($urandom_range(0, 7)),
                {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 99) == 0));
        end

        repeat (2) @(negedge Hclk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
